// File: rtl/control_unit_if.sv
// Control bundle between the control_unit sequencer (master) and the datapath (slave).
interface control_unit_if #(
   parameter int unsigned BITS      = 32,
   parameter int unsigned REGISTERS = 16
);
   logic [BITS-1:0]      IRVal;
   logic                 mem_ready;
   logic [REGISTERS-1:0] GPRin;
   logic [REGISTERS-1:0] GPRout;
   logic PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read;
   logic MDRout, LOout, HIout, RZHIout, RZLOout, PCout;
   logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
   logic MemWrite, run, illegal_op;

   modport master (
      input  IRVal, mem_ready,
      output GPRin, GPRout,
      output PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read,
      output MDRout, LOout, HIout, RZHIout, RZLOout, PCout,
      output ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC,
      output MemWrite, run, illegal_op
   );

   modport slave (
      output IRVal, mem_ready,
      input  GPRin, GPRout,
      input  PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read,
      input  MDRout, LOout, HIout, RZHIout, RZLOout, PCout,
      input  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC,
      input  MemWrite, run, illegal_op
   );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle Moore sequencer: fetch/decode/execute control for the datapath.
// Outputs are a decode of the state register and the datapath's IR contents.
module control_unit #(
   parameter int unsigned BITS      = 32,
   parameter int unsigned REGISTERS = 16
) (
   input  logic           clk,
   input  logic           reset,
   control_unit_if.master bus
);
   localparam int unsigned OP_W  = 5;
   localparam int unsigned REG_W = 4;

   localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OP_W-1:0] OP_ST   = 5'b00001;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b01010;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
   localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T1_WAIT, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      CL_ALU, CL_MULDIV, CL_UNARY, CL_MFHI, CL_MFLO,
      CL_LD, CL_ST, CL_NOP, CL_HALT, CL_ILLEGAL
   } class_t;

   state_t               state;
   state_t               state_nxt;
   class_t               cls;
   logic [BITS-1:0]      ir;
   logic [OP_W-1:0]      op;
   logic [REG_W-1:0]     ra, rb, rc;
   logic [REGISTERS-1:0] sel_ra, sel_rb, sel_rc;
   logic                 alu_go;
   logic                 unused_ir;

   assign ir        = bus.IRVal;
   assign op        = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir[14:0];
   assign sel_ra    = REGISTERS'(1) << ra;
   assign sel_rb    = REGISTERS'(1) << rb;
   assign sel_rc    = REGISTERS'(1) << rc;

   // Instruction class selects the execute sequence.
   always_comb begin
      cls = CL_ILLEGAL;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_ROR, OP_ROL, OP_SHR, OP_SHL: cls = CL_ALU;
         OP_MUL, OP_DIV:                 cls = CL_MULDIV;
         OP_NEG, OP_NOT:                 cls = CL_UNARY;
         OP_MFHI:                        cls = CL_MFHI;
         OP_MFLO:                        cls = CL_MFLO;
         OP_LD:                          cls = CL_LD;
         OP_ST:                          cls = CL_ST;
         OP_NOP:                         cls = CL_NOP;
         OP_HALT:                        cls = CL_HALT;
         default:                        cls = CL_ILLEGAL;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      alu_go         = 1'b0;
      bus.GPRin      = '0;
      bus.GPRout     = '0;
      bus.PCin       = 1'b0;
      bus.IRin       = 1'b0;
      bus.RYin       = 1'b0;
      bus.RZin       = 1'b0;
      bus.MARin      = 1'b0;
      bus.HIin       = 1'b0;
      bus.LOin       = 1'b0;
      bus.MDRin      = 1'b0;
      bus.Read       = 1'b0;
      bus.MDRout     = 1'b0;
      bus.LOout      = 1'b0;
      bus.HIout      = 1'b0;
      bus.RZHIout    = 1'b0;
      bus.RZLOout    = 1'b0;
      bus.PCout      = 1'b0;
      bus.ADD        = 1'b0;
      bus.SUB        = 1'b0;
      bus.MUL        = 1'b0;
      bus.DIV        = 1'b0;
      bus.SHR        = 1'b0;
      bus.SHL        = 1'b0;
      bus.ROR        = 1'b0;
      bus.ROL        = 1'b0;
      bus.AND        = 1'b0;
      bus.OR         = 1'b0;
      bus.NEGATE     = 1'b0;
      bus.NOT        = 1'b0;
      bus.IncPC      = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.illegal_op = 1'b0;
      bus.run        = (state != S_IDLE) && (state != S_HALT);

      case (state)
         S_IDLE: state_nxt = S_T0;
         S_T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.RZin  = 1'b1;
            state_nxt = S_T1;
         end
         S_T1: begin
            bus.RZLOout = 1'b1;
            bus.PCin    = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
            state_nxt   = bus.mem_ready ? S_T2 : S_T1_WAIT;
         end
         // PC already loaded in T1; only keep the read alive.
         S_T1_WAIT: begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
            if (bus.mem_ready) state_nxt = S_T2;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_nxt  = S_T3;
         end
         S_T3: begin
            state_nxt = S_T0;
            case (cls)
               CL_ALU, CL_MULDIV: begin
                  bus.GPRout = sel_rb;
                  bus.RYin   = 1'b1;
                  state_nxt  = S_T4;
               end
               CL_UNARY: begin
                  bus.GPRout = sel_rb;
                  alu_go     = 1'b1;
                  bus.RZin   = 1'b1;
                  state_nxt  = S_T4;
               end
               CL_MFHI: begin
                  bus.HIout = 1'b1;
                  bus.GPRin = sel_ra;
               end
               CL_MFLO: begin
                  bus.LOout = 1'b1;
                  bus.GPRin = sel_ra;
               end
               CL_LD, CL_ST: begin
                  bus.GPRout = sel_rb;
                  bus.MARin  = 1'b1;
                  state_nxt  = S_T4;
               end
               CL_HALT:    state_nxt      = S_HALT;
               CL_ILLEGAL: bus.illegal_op = 1'b1;
               default:    state_nxt      = S_T0;
            endcase
         end
         S_T4: begin
            state_nxt = S_T0;
            case (cls)
               CL_ALU, CL_MULDIV: begin
                  bus.GPRout = sel_rc;
                  alu_go     = 1'b1;
                  bus.RZin   = 1'b1;
                  state_nxt  = S_T5;
               end
               CL_UNARY: begin
                  bus.RZLOout = 1'b1;
                  bus.GPRin   = sel_ra;
               end
               CL_LD: begin
                  bus.Read  = 1'b1;
                  bus.MDRin = 1'b1;
                  state_nxt = bus.mem_ready ? S_T5 : S_T4;
               end
               CL_ST: begin
                  bus.GPRout = sel_ra;
                  bus.MDRin  = 1'b1;
                  state_nxt  = S_T5;
               end
               default: state_nxt = S_T0;
            endcase
         end
         S_T5: begin
            state_nxt = S_T0;
            case (cls)
               CL_ALU: begin
                  bus.RZLOout = 1'b1;
                  bus.GPRin   = sel_ra;
               end
               CL_MULDIV: begin
                  bus.RZLOout = 1'b1;
                  bus.LOin    = 1'b1;
                  state_nxt   = S_T6;
               end
               CL_LD: begin
                  bus.MDRout = 1'b1;
                  bus.GPRin  = sel_ra;
               end
               CL_ST: begin
                  bus.MemWrite = 1'b1;
                  state_nxt    = bus.mem_ready ? S_T0 : S_T5;
               end
               default: state_nxt = S_T0;
            endcase
         end
         S_T6: begin
            bus.RZHIout = 1'b1;
            bus.HIin    = 1'b1;
            state_nxt   = S_T0;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase

      // Single ALU strobe for the cycle that feeds RZ.
      if (alu_go) begin
         case (op)
            OP_ADD:  bus.ADD    = 1'b1;
            OP_SUB:  bus.SUB    = 1'b1;
            OP_AND:  bus.AND    = 1'b1;
            OP_OR:   bus.OR     = 1'b1;
            OP_ROR:  bus.ROR    = 1'b1;
            OP_ROL:  bus.ROL    = 1'b1;
            OP_SHR:  bus.SHR    = 1'b1;
            OP_SHL:  bus.SHL    = 1'b1;
            OP_MUL:  bus.MUL    = 1'b1;
            OP_DIV:  bus.DIV    = 1'b1;
            OP_NEG:  bus.NEGATE = 1'b1;
            OP_NOT:  bus.NOT    = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle control traces from an instruction-level model.
module tb_control_unit;
   localparam int unsigned BITS      = 32;
   localparam int unsigned REGISTERS = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   control_unit_if #(.BITS(BITS), .REGISTERS(REGISTERS)) bus ();
   control_unit #(.BITS(BITS), .REGISTERS(REGISTERS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [15:0] gin;
      logic [15:0] gout;
      logic pcin, irin, ryin, rzin, marin, hiin, loin, mdrin, rd;
      logic mdrout, loout, hiout, rzhiout, rzloout, pcout;
      logic add, sub, mul, div, shr, shl, ror, rol, and_, or_, neg, not_, incpc;
      logic memw, run, ill;
   } ctl_t;

   ctl_t got;
   ctl_t exp_q[$];
   logic mr_q[$];
   int   errors = 0;
   int   checks = 0;

   always_comb begin
      got         = '0;
      got.gin     = bus.GPRin;
      got.gout    = bus.GPRout;
      got.pcin    = bus.PCin;
      got.irin    = bus.IRin;
      got.ryin    = bus.RYin;
      got.rzin    = bus.RZin;
      got.marin   = bus.MARin;
      got.hiin    = bus.HIin;
      got.loin    = bus.LOin;
      got.mdrin   = bus.MDRin;
      got.rd      = bus.Read;
      got.mdrout  = bus.MDRout;
      got.loout   = bus.LOout;
      got.hiout   = bus.HIout;
      got.rzhiout = bus.RZHIout;
      got.rzloout = bus.RZLOout;
      got.pcout   = bus.PCout;
      got.add     = bus.ADD;
      got.sub     = bus.SUB;
      got.mul     = bus.MUL;
      got.div     = bus.DIV;
      got.shr     = bus.SHR;
      got.shl     = bus.SHL;
      got.ror     = bus.ROR;
      got.rol     = bus.ROL;
      got.and_    = bus.AND;
      got.or_     = bus.OR;
      got.neg     = bus.NEGATE;
      got.not_    = bus.NOT;
      got.incpc   = bus.IncPC;
      got.memw    = bus.MemWrite;
      got.run     = bus.run;
      got.ill     = bus.illegal_op;
   end

   function automatic logic [15:0] oh(input logic [3:0] r);
      return 16'(1) << r;
   endfunction

   function automatic ctl_t blank();
      ctl_t c;
      c     = '0;
      c.run = 1'b1;
      return c;
   endfunction

   function automatic ctl_t with_op(input ctl_t c, input logic [4:0] op);
      ctl_t r;
      r = c;
      case (op)
         5'd3:  r.add  = 1'b1;
         5'd4:  r.sub  = 1'b1;
         5'd5:  r.and_ = 1'b1;
         5'd6:  r.or_  = 1'b1;
         5'd7:  r.ror  = 1'b1;
         5'd8:  r.rol  = 1'b1;
         5'd9:  r.shr  = 1'b1;
         5'd10: r.shl  = 1'b1;
         5'd15: r.mul  = 1'b1;
         5'd16: r.div  = 1'b1;
         5'd17: r.neg  = 1'b1;
         5'd18: r.not_ = 1'b1;
         default: ;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'($urandom)};
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(1, 0));
   endfunction

   task automatic push(input ctl_t c, input logic mr);
      exp_q.push_back(c);
      mr_q.push_back(mr);
   endtask

   // Expected per-cycle controls (and mem_ready to drive) for one instruction.
   // w1 = cycles memory is not ready during fetch, wm = during ld/st data phase.
   task automatic build(input logic [31:0] ir, input int w1, input int wm);
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      ctl_t e;
      op = ir[31:27];
      ra = ir[26:23];
      rb = ir[22:19];
      rc = ir[18:15];
      exp_q.delete();
      mr_q.delete();
      e = blank(); e.pcout = 1; e.marin = 1; e.incpc = 1; e.rzin = 1; push(e, rnd_bit());
      e = blank(); e.rzloout = 1; e.pcin = 1; e.rd = 1; e.mdrin = 1; push(e, w1 == 0);
      for (int k = 1; k <= w1; k++) begin
         e = blank(); e.rd = 1; e.mdrin = 1; push(e, k == w1);
      end
      e = blank(); e.mdrout = 1; e.irin = 1; push(e, rnd_bit());
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd15, 5'd16: begin
            e = blank(); e.gout = oh(rb); e.ryin = 1; push(e, rnd_bit());
            e = with_op(blank(), op); e.gout = oh(rc); e.rzin = 1; push(e, rnd_bit());
            if (op == 5'd15 || op == 5'd16) begin
               e = blank(); e.rzloout = 1; e.loin = 1; push(e, rnd_bit());
               e = blank(); e.rzhiout = 1; e.hiin = 1; push(e, rnd_bit());
            end else begin
               e = blank(); e.rzloout = 1; e.gin = oh(ra); push(e, rnd_bit());
            end
         end
         5'd17, 5'd18: begin
            e = with_op(blank(), op); e.gout = oh(rb); e.rzin = 1; push(e, rnd_bit());
            e = blank(); e.rzloout = 1; e.gin = oh(ra); push(e, rnd_bit());
         end
         5'd24: begin e = blank(); e.hiout = 1; e.gin = oh(ra); push(e, rnd_bit()); end
         5'd25: begin e = blank(); e.loout = 1; e.gin = oh(ra); push(e, rnd_bit()); end
         5'd0: begin
            e = blank(); e.gout = oh(rb); e.marin = 1; push(e, rnd_bit());
            for (int k = 0; k <= wm; k++) begin
               e = blank(); e.rd = 1; e.mdrin = 1; push(e, k == wm);
            end
            e = blank(); e.mdrout = 1; e.gin = oh(ra); push(e, rnd_bit());
         end
         5'd1: begin
            e = blank(); e.gout = oh(rb); e.marin = 1; push(e, rnd_bit());
            e = blank(); e.gout = oh(ra); e.mdrin = 1; push(e, rnd_bit());
            for (int k = 0; k <= wm; k++) begin
               e = blank(); e.memw = 1; push(e, k == wm);
            end
         end
         5'd26, 5'd27: begin e = blank(); push(e, rnd_bit()); end
         default: begin e = blank(); e.ill = 1; push(e, rnd_bit()); end
      endcase
   endtask

   // Plays up to 'limit' cycles of the expected trace (limit<0: whole instruction).
   task automatic run_instr(input string name, input logic [31:0] ir,
                            input int w1, input int wm, input int limit);
      int n;
      int drv, alu;
      build(ir, w1, wm);
      n = (limit < 0 || limit > exp_q.size()) ? exp_q.size() : limit;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (got !== exp_q[i]) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, i, got, exp_q[i]);
         end
         drv = $countones({bus.MDRout, bus.LOout, bus.HIout, bus.RZHIout, bus.RZLOout, bus.PCout});
         alu = $countones({bus.ADD, bus.SUB, bus.MUL, bus.DIV, bus.SHR, bus.SHL, bus.ROR,
                           bus.ROL, bus.AND, bus.OR, bus.NEGATE, bus.NOT, bus.IncPC});
         checks++;
         if (drv > 1 || alu > 1 || (bus.Read && bus.MemWrite)) begin
            errors++;
            $display("FAIL %s invariants cycle %0d: drivers=%0d strobes=%0d rd=%b wr=%b required <=1,<=1,not both",
                     name, i, drv, alu, bus.Read, bus.MemWrite);
         end
         bus.mem_ready = mr_q[i];
         if (i == 0) bus.IRVal = ir;
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL %s: got %h expected all zero", name, got);
      end
   endtask

   // Assert reset now, hold two edges, release just after an edge: one IDLE cycle follows.
   task automatic apply_reset(input string name);
      #1 reset = 1'b0;
      #1 check_zero({name, "_asserted"});
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_zero({name, "_idle"});
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus.mem_ready = 1'b0;
      bus.IRVal     = '0;
      repeat (3) @(posedge clk);
      #1 check_zero("reset_state");
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_zero("idle_after_release");
      // Interrupt an add in T4 (T0,T1,T2,T3,T4 = 5 cycles).
      run_instr("add_cut", enc(5'd3, 4'd3, 4'd1, 4'd2), 0, 0, 5);
      apply_reset("mid_t4");
   endtask

   task automatic test_alu();
      run_instr("add_r3_r1_r2", enc(5'd3, 4'd3, 4'd1, 4'd2), 0, 0, -1);
      run_instr("sub_same_regs", enc(5'd4, 4'd5, 4'd5, 4'd5), 1, 0, -1);
      run_instr("neg", enc(5'd17, 4'd15, 4'd0, 4'd9), 0, 0, -1);
      run_instr("not", enc(5'd18, 4'd0, 4'd15, 4'd1), 0, 0, -1);
   endtask

   task automatic test_muldiv();
      run_instr("mul_r0_r4_r5", enc(5'd15, 4'd0, 4'd4, 4'd5), 0, 0, -1);
      run_instr("div", enc(5'd16, 4'd7, 4'd8, 4'd9), 2, 0, -1);
      run_instr("mfhi", enc(5'd24, 4'd11, 4'd0, 4'd0), 0, 0, -1);
      run_instr("mflo", enc(5'd25, 4'd12, 4'd0, 4'd0), 0, 0, -1);
   endtask

   task automatic test_mem();
      run_instr("ld_r2_r7", enc(5'd0, 4'd2, 4'd7, 4'd0), 2, 3, -1);
      run_instr("st_r6_r1", enc(5'd1, 4'd6, 4'd1, 4'd0), 0, 2, -1);
      run_instr("st_nowait", enc(5'd1, 4'd14, 4'd3, 4'd0), 0, 0, -1);
   endtask

   task automatic test_illegal_halt();
      run_instr("illegal_11111", enc(5'd31, 4'd1, 4'd2, 4'd3), 0, 0, -1);
      run_instr("nop_after_illegal", enc(5'd26, 4'd0, 4'd0, 4'd0), 0, 0, -1);
      run_instr("halt", enc(5'd27, 4'd0, 4'd0, 4'd0), 0, 0, -1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.mem_ready = rnd_bit();
         check_zero("halted");
      end
      apply_reset("after_halt");
      run_instr("add_after_halt", enc(5'd3, 4'd1, 4'd2, 4'd3), 0, 0, -1);
   endtask

   task automatic test_back_to_back();
      logic [4:0] op;
      for (int n = 0; n < 80; n++) begin
         op = 5'($urandom_range(31, 0));
         if (op == 5'd27) op = 5'd26;
         run_instr("random", enc(op, 4'($urandom), 4'($urandom), 4'($urandom)),
                   int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), -1);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_muldiv();
      test_mem();
      test_back_to_back();
      test_illegal_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
